// File: rtl/rs_issue_scheduler_pkg.sv
// rs_issue_scheduler_pkg: shared index-width helper and RS/ROB entry types.
package rs_issue_scheduler_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic ready;
        logic sent_to_alu;
    } rs_entry_t;

    typedef struct packed {
        logic valid;
        logic done;
    } rob_entry_t;

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// rs_issue_scheduler_if: RS/ALU-side signals of the issue scheduler.
interface rs_issue_scheduler_if
    import rs_issue_scheduler_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int IDX_W = idx_width(SIZE)
);
    logic             flush;
    logic [SIZE-1:0]  rs_valid;
    logic [SIZE-1:0]  rs_ready;
    logic             alu_ready;
    logic             alu_done;
    logic [IDX_W-1:0] alu_done_idx;
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic [SIZE-1:0]  issue_grant;
    logic [SIZE-1:0]  rs_free;
    logic [IDX_W:0]   inflight_cnt;

    modport master (
        input  flush, rs_valid, rs_ready, alu_ready, alu_done, alu_done_idx,
        output issue_valid, issue_idx, issue_grant, rs_free, inflight_cnt
    );

    modport slave (
        output flush, rs_valid, rs_ready, alu_ready, alu_done, alu_done_idx,
        input  issue_valid, issue_idx, issue_grant, rs_free, inflight_cnt
    );
endinterface

// File: rtl/rs_issue_scheduler_picker.sv
// rr_priority_picker: first set request at or after ptr, scanning circularly.
module rr_priority_picker
    import rs_issue_scheduler_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int IDX_W = idx_width(SIZE)
) (
    input  logic [SIZE-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    int p;
    logic [IDX_W-1:0] q;

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        p     = 0;
        q     = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            p = int'(ptr) + i;
            p = (p >= SIZE) ? p - SIZE : p;
            q = IDX_W'(p);
            if (req[q]) begin
                found = 1'b1;
                idx   = q;
            end
        end
    end
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: round-robin issue of ready RS entries to a single ALU
// with an in-flight limit and per-entry grant/free pulses.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int IDX_W        = idx_width(SIZE),
    parameter int MAX_INFLIGHT = 2
) (
    input logic clk,
    input logic rst,
    rs_issue_scheduler_if.master bus
);
    logic             offer_valid;
    logic [IDX_W-1:0] offer_idx;
    logic [SIZE-1:0]  issued, issued_next;
    logic [IDX_W-1:0] rr_ptr, ptr_next;
    logic [IDX_W:0]   cnt, cnt_next;
    logic [SIZE-1:0]  grant, free_pulse;
    logic [SIZE-1:0]  acc_oh, done_oh, offer_oh, cand;
    logic             accept, done_hit, room, found;
    logic [IDX_W-1:0] pick;

    always_comb begin
        accept      = offer_valid & bus.alu_ready;
        done_hit    = bus.alu_done & issued[bus.alu_done_idx];
        acc_oh      = accept ? (SIZE'(1) << offer_idx) : '0;
        done_oh     = done_hit ? (SIZE'(1) << bus.alu_done_idx) : '0;
        offer_oh    = offer_valid ? (SIZE'(1) << offer_idx) : '0;
        issued_next = (issued | acc_oh) & ~done_oh;
        cnt_next    = cnt + (IDX_W+1)'(accept) - (IDX_W+1)'(done_hit);
        room        = cnt_next < (IDX_W+1)'(MAX_INFLIGHT);
        ptr_next    = accept ? ((offer_idx == IDX_W'(SIZE - 1)) ? '0 : offer_idx + 1'b1) : rr_ptr;
        // Old issued mask keeps a just-completed entry out of this cycle's pick.
        cand        = bus.rs_valid & bus.rs_ready & ~issued & ~offer_oh;
    end

    rr_priority_picker #(.SIZE(SIZE), .IDX_W(IDX_W)) u_picker (
        .req   (cand),
        .ptr   (ptr_next),
        .found (found),
        .idx   (pick)
    );

    always_ff @(posedge clk) begin
        if (rst | bus.flush) begin
            offer_valid <= 1'b0;
            offer_idx   <= '0;
            issued      <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            grant       <= '0;
            free_pulse  <= '0;
        end else begin
            issued     <= issued_next;
            rr_ptr     <= ptr_next;
            cnt        <= cnt_next;
            grant      <= acc_oh;
            free_pulse <= done_oh;
            if (~offer_valid | bus.alu_ready) begin
                offer_valid <= found & room;
                if (found & room) offer_idx <= pick;
            end
        end
    end

    assign bus.issue_valid  = offer_valid;
    assign bus.issue_idx    = offer_idx;
    assign bus.issue_grant  = grant;
    assign bus.rs_free      = free_pulse;
    assign bus.inflight_cnt = cnt;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed checks of reset, round-robin, hold, throttle,
// simultaneous accept/complete and flush; two instances differ only in MAX_INFLIGHT.
module tb_rs_issue_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [7:0] rs_valid = '0, rs_ready = '0;
    logic alu_ready = 1'b0, alu_done = 1'b0;
    logic [2:0] alu_done_idx = '0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler_if #(.SIZE(8), .IDX_W(3)) if8 ();
    rs_issue_scheduler_if #(.SIZE(8), .IDX_W(3)) if2 ();

    assign if8.flush = flush;        assign if2.flush = flush;
    assign if8.rs_valid = rs_valid;  assign if2.rs_valid = rs_valid;
    assign if8.rs_ready = rs_ready;  assign if2.rs_ready = rs_ready;
    assign if8.alu_ready = alu_ready; assign if2.alu_ready = alu_ready;
    assign if8.alu_done = alu_done;  assign if2.alu_done = alu_done;
    assign if8.alu_done_idx = alu_done_idx; assign if2.alu_done_idx = alu_done_idx;

    rs_issue_scheduler #(.SIZE(8), .IDX_W(3), .MAX_INFLIGHT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    rs_issue_scheduler #(.SIZE(8), .IDX_W(3), .MAX_INFLIGHT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; rs_valid = '0; rs_ready = '0;
        alu_ready = 1'b0; alu_done = 1'b0; alu_done_idx = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rs_valid = 8'hFF; rs_ready = 8'hFF; alu_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (if2.issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if2.issue_valid); end
            n_cmp++; if (if2.inflight_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", if2.inflight_cnt); end
        end
        rst = 1'b0;
        step();
        n_cmp++; if (if2.issue_valid !== 1'b1 || if2.issue_idx !== 3'd0) begin n_bad++; $display("FAIL reset_release got v=%b idx=%0d want v=1 idx=0", if2.issue_valid, if2.issue_idx); end
        n_cmp++; if (if2.issue_grant !== 8'h00) begin n_bad++; $display("FAIL reset_grant got %h want 00", if2.issue_grant); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [7:0] exp_gnt [4] = '{8'h00, 8'h01, 8'h04, 8'h20};
        do_reset();
        rs_valid = 8'b1010_0101; rs_ready = 8'b1010_0101; alu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (if8.issue_valid !== 1'b1 || if8.issue_idx !== exp_idx[k]) begin n_bad++; $display("FAIL rr_idx[%0d] got v=%b idx=%0d want v=1 idx=%0d", k, if8.issue_valid, if8.issue_idx, exp_idx[k]); end
            n_cmp++; if (if8.issue_grant !== exp_gnt[k]) begin n_bad++; $display("FAIL rr_grant[%0d] got %h want %h", k, if8.issue_grant, exp_gnt[k]); end
        end
        step();
        n_cmp++; if (if8.issue_valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty got v=%b want 0", if8.issue_valid); end
        n_cmp++; if (if8.issue_grant !== 8'h80) begin n_bad++; $display("FAIL rr_last_grant got %h want 80", if8.issue_grant); end
        n_cmp++; if (if8.inflight_cnt !== 4'd4) begin n_bad++; $display("FAIL rr_cnt got %0d want 4", if8.inflight_cnt); end
        alu_ready = 1'b0;
        step();
        n_cmp++; if (if8.issue_grant !== 8'h00) begin n_bad++; $display("FAIL rr_grant_pulse got %h want 00", if8.issue_grant); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rs_valid = 8'h08; rs_ready = 8'h08; alu_ready = 1'b0;
        step();
        rs_valid = 8'h0A; rs_ready = 8'h0A;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++; if (if2.issue_valid !== 1'b1 || if2.issue_idx !== 3'd3) begin n_bad++; $display("FAIL hold[%0d] got v=%b idx=%0d want v=1 idx=3", c, if2.issue_valid, if2.issue_idx); end
        end
        alu_ready = 1'b1;
        step();
        n_cmp++; if (if2.issue_grant !== 8'h08) begin n_bad++; $display("FAIL hold_grant got %h want 08", if2.issue_grant); end
        n_cmp++; if (if2.issue_valid !== 1'b1 || if2.issue_idx !== 3'd1) begin n_bad++; $display("FAIL hold_wrap got v=%b idx=%0d want v=1 idx=1", if2.issue_valid, if2.issue_idx); end
        alu_ready = 1'b0;
        step();
        n_cmp++; if (if2.issue_grant !== 8'h00 || if2.inflight_cnt !== 4'd1) begin n_bad++; $display("FAIL hold_after got grant=%h cnt=%0d want grant=00 cnt=1", if2.issue_grant, if2.inflight_cnt); end
    endtask

    task automatic test_throttle();
        do_reset();
        rs_valid = 8'h07; rs_ready = 8'h07; alu_ready = 1'b1;
        step();
        step();
        n_cmp++; if (if2.issue_grant !== 8'h01 || if2.issue_idx !== 3'd1) begin n_bad++; $display("FAIL thr_first got grant=%h idx=%0d want grant=01 idx=1", if2.issue_grant, if2.issue_idx); end
        step();
        n_cmp++; if (if2.issue_grant !== 8'h02 || if2.issue_valid !== 1'b0 || if2.inflight_cnt !== 4'd2) begin n_bad++; $display("FAIL thr_full got grant=%h v=%b cnt=%0d want grant=02 v=0 cnt=2", if2.issue_grant, if2.issue_valid, if2.inflight_cnt); end
        step();
        n_cmp++; if (if2.issue_valid !== 1'b0 || if2.issue_grant !== 8'h00) begin n_bad++; $display("FAIL thr_stall got v=%b grant=%h want v=0 grant=00", if2.issue_valid, if2.issue_grant); end
        alu_done = 1'b1; alu_done_idx = 3'd0; alu_ready = 1'b0;
        step();
        alu_done = 1'b0;
        n_cmp++; if (if2.rs_free !== 8'h01 || if2.inflight_cnt !== 4'd1) begin n_bad++; $display("FAIL thr_free got free=%h cnt=%0d want free=01 cnt=1", if2.rs_free, if2.inflight_cnt); end
        n_cmp++; if (if2.issue_valid !== 1'b1 || if2.issue_idx !== 3'd2) begin n_bad++; $display("FAIL thr_reoffer got v=%b idx=%0d want v=1 idx=2", if2.issue_valid, if2.issue_idx); end
        step();
        n_cmp++; if (if2.rs_free !== 8'h00) begin n_bad++; $display("FAIL thr_free_pulse got %h want 00", if2.rs_free); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        rs_valid = 8'h02; rs_ready = 8'h02; alu_ready = 1'b1;
        step();
        step();
        rs_valid = 8'h12; rs_ready = 8'h12;
        step();
        n_cmp++; if (if2.issue_valid !== 1'b1 || if2.issue_idx !== 3'd4 || if2.inflight_cnt !== 4'd1) begin n_bad++; $display("FAIL sim_setup got v=%b idx=%0d cnt=%0d want v=1 idx=4 cnt=1", if2.issue_valid, if2.issue_idx, if2.inflight_cnt); end
        alu_done = 1'b1; alu_done_idx = 3'd1;
        step();
        n_cmp++; if (if2.issue_grant !== 8'h10 || if2.rs_free !== 8'h02) begin n_bad++; $display("FAIL sim_pulses got grant=%h free=%h want grant=10 free=02", if2.issue_grant, if2.rs_free); end
        n_cmp++; if (if2.inflight_cnt !== 4'd1 || if2.issue_valid !== 1'b0) begin n_bad++; $display("FAIL sim_cnt got cnt=%0d v=%b want cnt=1 v=0", if2.inflight_cnt, if2.issue_valid); end
        alu_done_idx = 3'd6; alu_ready = 1'b0;
        step();
        alu_done = 1'b0;
        n_cmp++; if (if2.rs_free !== 8'h00 || if2.inflight_cnt !== 4'd1) begin n_bad++; $display("FAIL sim_spurious got free=%h cnt=%0d want free=00 cnt=1", if2.rs_free, if2.inflight_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        rs_valid = 8'h07; rs_ready = 8'h07; alu_ready = 1'b1;
        step(); step(); step();
        n_cmp++; if (if8.issue_valid !== 1'b1 || if8.issue_idx !== 3'd2 || if8.inflight_cnt !== 4'd2) begin n_bad++; $display("FAIL fl_setup got v=%b idx=%0d cnt=%0d want v=1 idx=2 cnt=2", if8.issue_valid, if8.issue_idx, if8.inflight_cnt); end
        alu_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; rs_valid = '0; rs_ready = '0;
        n_cmp++; if (if8.issue_valid !== 1'b0 || if8.inflight_cnt !== 4'd0) begin n_bad++; $display("FAIL fl_clear got v=%b cnt=%0d want v=0 cnt=0", if8.issue_valid, if8.inflight_cnt); end
        n_cmp++; if (if8.issue_grant !== 8'h00 || if8.rs_free !== 8'h00) begin n_bad++; $display("FAIL fl_pulses got grant=%h free=%h want 00/00", if8.issue_grant, if8.rs_free); end
        n_cmp++; if (if2.inflight_cnt !== 4'd0) begin n_bad++; $display("FAIL fl_cnt2 got %0d want 0", if2.inflight_cnt); end
        alu_done = 1'b1; alu_done_idx = 3'd0;
        step();
        alu_done = 1'b0;
        n_cmp++; if (if8.rs_free !== 8'h00 || if8.inflight_cnt !== 4'd0) begin n_bad++; $display("FAIL fl_stale_done got free=%h cnt=%0d want free=00 cnt=0", if8.rs_free, if8.inflight_cnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_throttle();
        test_simultaneous();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
